// File: rtl/uart_pkg.sv
// Shared receiver types: FSM state encoding and the baud-timing constant functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int unsigned bit_cyc(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned half_cyc(input int unsigned clk_hz, input int unsigned baud);
    return bit_cyc(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; the head entry is always visible on dout while not empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             overrun_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign overrun = overrun_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      overrun_reg <= push && !do_push;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, start/data/stop FSM and a FWFT byte buffer.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STG   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BIT_CYC  = int'(bit_cyc(CLK_HZ, BAUD));
  localparam int HALF_CYC = int'(half_cyc(CLK_HZ, BAUD));
  localparam int CW       = $clog2(BIT_CYC);

  logic [SYNC_STG-1:0] sync_reg;
  logic [SYNC_STG-1:0] settle_reg;
  logic                rxs;
  logic                rxs_prev_reg;
  logic                line_ok;
  logic                fall;

  rx_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          push_reg, push_next;
  logic          frame_err_reg, frame_err_next;
  logic          fifo_full;
  logic          fifo_empty;

  assign rxs = sync_reg[SYNC_STG-1];
  // settle_reg marks when rxs carries real line samples rather than reset ones,
  // so a line already low after reset never looks like a start edge.
  assign line_ok = settle_reg[SYNC_STG-1];
  assign fall    = line_ok && rxs_prev_reg && !rxs;
  assign busy    = (state_reg != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg      <= '1;
      settle_reg    <= '0;
      rxs_prev_reg  <= 1'b0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STG-2:0], uart_rx};
      settle_reg    <= {settle_reg[SYNC_STG-2:0], 1'b1};
      rxs_prev_reg  <= line_ok ? rxs : 1'b0;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      push_reg      <= push_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    push_next      = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (fall) state_next = ST_START;
      end
      ST_START: begin
        if (cnt_reg == CW'(HALF_CYC - 1)) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg == CW'(BIT_CYC - 1)) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rxs;
          idx_next            = idx_reg + 1'b1;
          if (idx_reg == 3'd7) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_reg == CW'(BIT_CYC - 1)) begin
          cnt_next = '0;
          if (rxs) begin
            push_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_next = '0;
        if (rxs) state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign frame_err = frame_err_reg;
  assign rx_valid  = !fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_reg),
    .din     (shift_reg),
    .pop     (rx_ready),
    .dout    (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus queues expected bytes, a monitor checks every pop.
module tb_uart_rx_core;

  // Fast line rate keeps each frame a few thousand cycles.
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 192_000;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic [7:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       push_seen;

  uart_rx_core #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4),
    .SYNC_STG   (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts flag pulses, checks head stability and every popped byte.
  always @(negedge clk) begin
    if (rst) begin
      check("rx_valid_in_reset", rx_valid, 0);
      prev_hold = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (prev_hold && rx_valid) check("head_stable", rx_data, prev_data);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", rx_data, 32'hFFFF_FFFF);
        end else begin
          $display("[TB] pop %02h expected %02h", rx_data, exp_q[0]);
          check("pop_data", rx_data, exp_q.pop_front());
        end
      end
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  initial begin
    #(200_000 * 20);
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int tail_low);
    uart_rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(BIT);
    end
    uart_rx = stop_bit;
    wait_cyc(BIT);
    if (tail_low > 0) wait_cyc(tail_low);
    uart_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    rx_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) wait_cyc(1);
    wait_cyc(2);
    rx_ready = 1'b0;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_empty"}, rx_valid, 0);
  endtask

  initial begin
    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    wait_cyc(4);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    wait_cyc(10);

    // 1: single frame, consumer always ready
    rx_ready = 1'b1;
    exp_q.push_back(8'hB6);
    send_frame(8'hB6, 1'b1, 0);
    wait_cyc(5);
    check("t1_popped", exp_q.size(), 0);
    check("t1_valid_low", rx_valid, 0);
    check("t1_frame_err", fe_cnt, 0);
    check("t1_overrun", ov_cnt, 0);
    rx_ready = 1'b0;

    // 2: four back-to-back frames buffered, then popped in order
    exp_q.push_back(8'hE7);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hB4);
    send_frame(8'hE7, 1'b1, 0);
    send_frame(8'hF0, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    send_frame(8'hB4, 1'b1, 0);
    wait_cyc(5);
    check("t2_valid", rx_valid, 1);
    check("t2_head", rx_data, 8'hE7);
    check("t2_overrun", ov_cnt, 0);
    drain("t2");

    // 3: short low glitch is a false start
    uart_rx = 1'b0;
    wait_cyc(10);
    check("t3_busy_high", busy, 1);
    wait_cyc(40);
    uart_rx = 1'b1;
    wait_cyc(HALF + SYNC - 2 - 50);
    check("t3_busy_before_sample", busy, 1);
    wait_cyc(6);
    check("t3_busy_low", busy, 0);
    check("t3_no_byte", rx_valid, 0);
    check("t3_no_frame_err", fe_cnt, 0);

    // 4: bad stop bit with a held-low line, then a good frame
    wait_cyc(BIT);
    send_frame(8'h55, 1'b0, 3 * BIT);
    wait_cyc(BIT);
    check("t4_frame_err_once", fe_cnt, 1);
    check("t4_no_push", rx_valid, 0);
    check("t4_idle", busy, 0);
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b1, 0);
    wait_cyc(5);
    check("t4_good_valid", rx_valid, 1);
    drain("t4");
    check("t4_frame_err_total", fe_cnt, 1);

    // 5a: fifth frame into a full FIFO is dropped with one overrun
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hB0 + 8'(i));
    for (int i = 0; i < 5; i++) send_frame(8'hB0 + 8'(i), 1'b1, 0);
    wait_cyc(5);
    check("t5_overrun_once", ov_cnt, 1);
    check("t5_head", rx_data, 8'hB0);
    drain("t5a");

    // 5b: pop in the push cycle of the fifth frame avoids the overrun
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hB0 + 8'(i));
    for (int i = 0; i < 4; i++) send_frame(8'hB0 + 8'(i), 1'b1, 0);
    push_seen = 1'b0;
    fork
      send_frame(8'hB4, 1'b1, 0);
      begin
        for (int n = 0; n < 12 * BIT && !push_seen; n++) begin
          wait_cyc(1);
          if (dut.push_reg) push_seen = 1'b1;
        end
        if (push_seen) begin
          rx_ready = 1'b1;
          wait_cyc(1);
          rx_ready = 1'b0;
        end
      end
    join
    check("t5b_push_seen", push_seen, 1);
    wait_cyc(5);
    check("t5b_no_overrun", ov_cnt, 1);
    check("t5b_head", rx_data, 8'hB1);
    drain("t5b");

    // 6: reset in the middle of data bit 3 of 0xE5, then a clean 0xB6
    fork
      send_frame(8'hE5, 1'b1, 0);
      begin
        wait_cyc(4 * BIT + HALF);
        rst = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(3);
        check("t6_busy_after_rst", busy, 0);
      end
    join
    wait_cyc(BIT);
    check("t6_no_e5", rx_valid, 0);
    check("t6_idle", busy, 0);
    exp_q.push_back(8'hB6);
    send_frame(8'hB6, 1'b1, 0);
    wait_cyc(5);
    check("t6_b6_valid", rx_valid, 1);
    check("t6_b6_head", rx_data, 8'hB6);
    drain("t6");
    check("t6_frame_err_total", fe_cnt, 1);
    check("t6_overrun_total", ov_cnt, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
